// File: rtl/scan_master_ctrl.sv
// Scan master: turns a command word into two-phase scan pad sequences that
// write a configuration vector into a chain or capture and read one back.
module scan_master_ctrl #(
  parameter int MAX_BITS  = 64,
  parameter int PHASE_CYC = 2,
  parameter int GAP_CYC   = 1,
  parameter int LOAD_CYC  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_op,
  input  logic                          cmd_id,
  input  logic [$clog2(MAX_BITS+1)-1:0] cmd_len,
  input  logic [MAX_BITS-1:0]           cmd_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [MAX_BITS-1:0]           rsp_data,
  output logic                          busy,
  output logic                          scan_phi,
  output logic                          scan_phi_bar,
  output logic                          scan_data_in,
  output logic                          scan_load_chip,
  output logic                          scan_load_chain,
  output logic                          scan_id,
  input  logic                          scan_data_out
);

  localparam int LEN_W = $clog2(MAX_BITS + 1);
  localparam int IDX_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam int CNT_W = 16;

  localparam logic [CNT_W-1:0] PHASE_M1 = CNT_W'(PHASE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_M1   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] LOAD_M1  = CNT_W'(LOAD_CYC - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_BITS);

  typedef enum logic [3:0] {
    IDLE,
    LDCHAIN,
    SETUP,
    PHI,
    GAP1,
    PHIB,
    GAP2,
    LDCHIP,
    RESP
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [LEN_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic                op_reg, op_next;
  logic                id_reg, id_next;
  logic [MAX_BITS-1:0] data_reg, data_next;
  logic [MAX_BITS-1:0] rsp_data_reg, rsp_data_next;
  logic                din_reg, din_next;
  logic [LEN_W-1:0]    len_clamped;
  logic [IDX_W-1:0]    bit_idx;

  logic cmd_ready_reg, busy_reg, rsp_valid_reg;
  logic phi_reg, phi_bar_reg, load_chip_reg, load_chain_reg, scan_id_reg;

  assign len_clamped = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    op_next       = op_reg;
    id_next       = id_reg;
    data_next     = data_reg;
    rsp_data_next = rsp_data_reg;
    din_next      = din_reg;
    bit_idx       = '0;

    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready_reg) begin
          op_next       = cmd_op;
          id_next       = cmd_id;
          data_next     = cmd_data;
          bit_cnt_next  = len_clamped;
          rsp_data_next = '0;
          if (cmd_op) begin
            state_next = LDCHAIN;
            cnt_next   = LOAD_M1;
          end else if (len_clamped != '0) begin
            state_next = SETUP;
          end else begin
            state_next = LDCHIP;
            cnt_next   = LOAD_M1;
          end
        end
      end
      LDCHAIN: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (bit_cnt_reg != '0) begin
          state_next = SETUP;
        end else begin
          state_next = RESP;
        end
      end
      SETUP: begin
        state_next = PHI;
        cnt_next   = PHASE_M1;
      end
      PHI: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          state_next = GAP1;
          cnt_next   = GAP_M1;
        end
      end
      GAP1: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          state_next = PHIB;
          cnt_next   = PHASE_M1;
        end
      end
      PHIB: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          // Chain output is valid by the end of the phi_bar pulse.
          if (op_reg) rsp_data_next = {rsp_data_reg[MAX_BITS-2:0], scan_data_out};
          state_next = GAP2;
          cnt_next   = GAP_M1;
        end
      end
      GAP2: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          bit_cnt_next = bit_cnt_reg - 1'b1;
          if (bit_cnt_reg != LEN_W'(1)) begin
            state_next = SETUP;
          end else if (op_reg) begin
            state_next = RESP;
          end else begin
            state_next = LDCHIP;
            cnt_next   = LOAD_M1;
          end
        end
      end
      LDCHIP: begin
        if (cnt_reg != '0) cnt_next = cnt_reg - 1'b1;
        else               state_next = IDLE;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Data pin only moves on entry to SETUP or LDCHIP; writes go MSB-first.
    if (state_next == SETUP) begin
      bit_idx  = IDX_W'(bit_cnt_next - LEN_W'(1));
      din_next = op_next ? 1'b0 : data_next[bit_idx];
    end else if (state_next == LDCHIP) begin
      din_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      bit_cnt_reg    <= '0;
      op_reg         <= 1'b0;
      id_reg         <= 1'b0;
      data_reg       <= '0;
      rsp_data_reg   <= '0;
      din_reg        <= 1'b0;
      cmd_ready_reg  <= 1'b1;
      busy_reg       <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      phi_reg        <= 1'b0;
      phi_bar_reg    <= 1'b0;
      load_chip_reg  <= 1'b0;
      load_chain_reg <= 1'b0;
      scan_id_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      op_reg         <= op_next;
      id_reg         <= id_next;
      data_reg       <= data_next;
      rsp_data_reg   <= rsp_data_next;
      din_reg        <= din_next;
      // Pad drives are decoded from the next state so they line up with it.
      cmd_ready_reg  <= (state_next == IDLE);
      busy_reg       <= (state_next != IDLE);
      rsp_valid_reg  <= (state_next == RESP);
      phi_reg        <= (state_next == PHI);
      phi_bar_reg    <= (state_next == PHIB);
      load_chip_reg  <= (state_next == LDCHIP);
      load_chain_reg <= (state_next == LDCHAIN);
      scan_id_reg    <= (state_next != IDLE) && id_next;
    end
  end

  assign cmd_ready       = cmd_ready_reg;
  assign busy            = busy_reg;
  assign rsp_valid       = rsp_valid_reg;
  assign rsp_data        = rsp_data_reg;
  assign scan_phi        = phi_reg;
  assign scan_phi_bar    = phi_bar_reg;
  assign scan_data_in    = din_reg;
  assign scan_load_chip  = load_chip_reg;
  assign scan_load_chain = load_chain_reg;
  assign scan_id         = scan_id_reg;

endmodule

// File: doc/scan_master_ctrl.md
Name: scan_master_ctrl

Overview:
- On-chip scan master: accepts a command word, then sequences the two-phase scan pads (scan_phi, scan_phi_bar, scan_data_in, scan_load_chip, scan_load_chain, scan_id) to write a configuration vector into a chain or capture and read one back.
- Replaces the behavioural bench-side scan driver with synthesizable RTL.
- Sits between a core-side command interface and the scan pad inputs of top.

Parameters:
- MAX_BITS, 64, maximum chain length per command (shift buffer width).
- PHASE_CYC, 2, clk cycles each of scan_phi/scan_phi_bar is held high (>=1).
- GAP_CYC, 1, non-overlap clk cycles after each phase with both phases low (>=1).
- LOAD_CYC, 2, clk cycles scan_load_chip/scan_load_chain is held high (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  controller idle; a command is accepted when cmd_valid && cmd_ready.
- cmd_op  in  1  0 = write (shift then load_chip), 1 = read (load_chain then shift).
- cmd_id  in  1  chain select, driven onto scan_id for the whole command.
- cmd_len  in  $clog2(MAX_BITS+1)  number of bits to shift.
- cmd_data  in  MAX_BITS  write vector; bits [cmd_len-1:0] are used.
- rsp_valid  out  1  read result available.
- rsp_ready  in  1  result consumed when rsp_valid && rsp_ready.
- rsp_data  out  MAX_BITS  captured bits, right-justified, upper bits zero.
- busy  out  1  high in every state except IDLE.
- scan_phi, scan_phi_bar, scan_data_in, scan_load_chip, scan_load_chain, scan_id  out  1  scan pad drives.
- scan_data_out  in  1  chain serial output.

Behaviour:
- All outputs are registered. Reset values: every scan_* output 0, rsp_valid 0, rsp_data 0, busy 0, cmd_ready 1. Reset has priority over everything in any state; it aborts an in-flight command with no load pulse and no response.
- States: IDLE, LDCHAIN, SETUP, PHI, GAP1, PHIB, GAP2, LDCHIP, RESP.
- IDLE: on accept, latch op, id, data and len. A len above MAX_BITS is clamped to MAX_BITS. cmd_ready drops in the cycle after accept, and scan_id = cmd_id from that cycle until the command returns to IDLE.
  - Read goes to LDCHAIN.
  - Write with len>0 goes to SETUP; write with len=0 goes to LDCHIP.
- LDCHAIN: scan_load_chain=1 for LOAD_CYC cycles. Then SETUP if len>0, else RESP with rsp_data=0.
- Per bit, 1+2*PHASE_CYC+2*GAP_CYC cycles (7 with defaults):
  - SETUP, 1 cycle: scan_data_in = next bit. Write sends MSB-first (bit len-1 first, bit 0 last); read drives 0.
  - PHI: scan_phi=1 for PHASE_CYC cycles.
  - GAP1: both phases 0 for GAP_CYC cycles.
  - PHIB: scan_phi_bar=1 for PHASE_CYC cycles.
  - GAP2: both phases 0 for GAP_CYC cycles.
  - scan_data_in is held stable from SETUP through GAP2.
  - Read samples scan_data_out on the last PHIB cycle and shifts it into rsp_data LSB-ward. The first sampled bit ends at rsp_data[len-1], the last at rsp_data[0].
  - scan_phi and scan_phi_bar are never high in the same cycle.
- After GAP2 the bit counter decrements. If nonzero, go to SETUP. At zero, write goes to LDCHIP and read goes to RESP.
- LDCHIP: scan_data_in=0 and scan_load_chip=1 for LOAD_CYC cycles, then IDLE.
- RESP: rsp_valid=1, rsp_data stable. Leave to IDLE on rsp_ready; rsp_ready=1 on the first RESP cycle gives a 1-cycle RESP.
- cmd_valid is ignored while busy. cmd_ready is 1 only in IDLE, so back-to-back commands have at least one IDLE cycle between them.
- Write latency, accept to return to IDLE, with defaults: 1 + 7*len + LOAD_CYC cycles.

Test Plan:
- Reset mid-shift: assert rst during a PHI cycle -> next cycle all scan_* = 0, busy=0, cmd_ready=1; no scan_load_chip pulse and no rsp_valid ever follows.
- Write, cmd_len=4, cmd_data=4'b1011, cmd_id=1 -> scan_data_in per bit = 1,0,1,1; exactly 4 phi and 4 phi_bar pulses, each 2 cycles wide with 1-cycle gaps; one 2-cycle scan_load_chip; scan_id=1 throughout; 31 cycles accept-to-IDLE.
- Read, cmd_len=8, bench chain model returns 0xA5 MSB-first -> one 2-cycle scan_load_chain before the first phi; rsp_valid with rsp_data=0x00000000000000A5; rsp_valid held for 5 cycles of rsp_ready=0, then cleared one cycle after rsp_ready=1.
- Length edge cases: write len=0 -> no phi pulses, scan_load_chip only; read len=0 -> load_chain only, rsp_data=0; len=100 -> clamped to 64 shifts.
- Non-overlap check: assertion over a 64-bit write and a 64-bit read that !(scan_phi && scan_phi_bar) in every cycle, and that scan_data_in changes only in SETUP/LDCHIP.
- cmd_valid held high while busy during a write -> no second accept until IDLE; second command accepted on the first IDLE cycle.
